// File: rtl/dyt_sram_arbiter.sv
// rtl/dyt_sram_arbiter.sv - instruction/data port arbiter and sequencer for the single-port SRAM wrapper
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed data-over-instruction priority.
module dyt_sram_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int BYTE_LANES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ireq,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  output logic                  iack,
  output logic [DATA_WIDTH-1:0] irdata,
  input  logic                  dren,
  input  logic [BYTE_LANES-1:0] dwen,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dack,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_w_data,
  output logic [BYTE_LANES-1:0] sram_wen,
  output logic                  sram_ren,
  input  logic [DATA_WIDTH-1:0] sram_r_data,
  output logic                  busy
);
  localparam int CNT_W = $clog2(READ_LATENCY + 2);
  localparam logic GNT_INSTR = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  iack_q, iack_d;
  logic                  dack_q, dack_d;
  logic [DATA_WIDTH-1:0] irdata_q, irdata_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
  logic [ADDR_WIDTH-1:0] sram_address_q, sram_address_d;
  logic [DATA_WIDTH-1:0] sram_w_data_q, sram_w_data_d;
  logic [BYTE_LANES-1:0] sram_wen_q, sram_wen_d;
  logic                  sram_ren_q, sram_ren_d;
  logic                  busy_q, busy_d;

  logic dreq;
  logic any_req;
  logic pick_data;
  logic read_done;

  assign dreq    = dren | (|dwen);
  assign any_req = ireq | dreq;

`ifdef SRAM_ARB_RR_EN
  // On contention the port that did not win last time gets the SRAM.
  assign pick_data = dreq && (!ireq || (last_grant_q == GNT_INSTR));
`else
  assign pick_data = dreq;
`endif

  // Last READ cycle: the wrapper output has settled after READ_LATENCY enabled edges.
  assign read_done = (cnt_q == CNT_W'(READ_LATENCY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      grant_q        <= GNT_INSTR;
      last_grant_q   <= GNT_INSTR;
      iack_q         <= 1'b0;
      dack_q         <= 1'b0;
      irdata_q       <= '0;
      drdata_q       <= '0;
      sram_address_q <= '0;
      sram_w_data_q  <= '0;
      sram_wen_q     <= '0;
      sram_ren_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      iack_q         <= iack_d;
      dack_q         <= dack_d;
      irdata_q       <= irdata_d;
      drdata_q       <= drdata_d;
      sram_address_q <= sram_address_d;
      sram_w_data_q  <= sram_w_data_d;
      sram_wen_q     <= sram_wen_d;
      sram_ren_q     <= sram_ren_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = pick_data ? GNT_DATA : GNT_INSTR;
          last_grant_d = pick_data ? GNT_DATA : GNT_INSTR;
          if (pick_data && (|dwen)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            cnt_d   = '0;
          end
        end
      end
      WRITE: state_d = RESP;
      READ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (read_done) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sram_address_d = sram_address_q;
    sram_w_data_d  = sram_w_data_q;
    sram_wen_d     = '0;
    sram_ren_d     = 1'b0;
    irdata_d       = irdata_q;
    drdata_d       = drdata_q;
    iack_d         = 1'b0;
    dack_d         = 1'b0;
    busy_d         = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (pick_data) begin
            sram_address_d = daddr;
            sram_w_data_d  = dwdata;
            if (|dwen) sram_wen_d = dwen;
            else       sram_ren_d = 1'b1;
          end else begin
            sram_address_d = iaddr;
            sram_ren_d     = 1'b1;
          end
        end
      end
      READ: begin
        if (read_done) begin
          if (grant_q == GNT_DATA) drdata_d = sram_r_data;
          else                     irdata_d = sram_r_data;
        end else begin
          sram_ren_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d == RESP) begin
      iack_d = (grant_q == GNT_INSTR);
      dack_d = (grant_q == GNT_DATA);
    end
  end

  assign iack         = iack_q;
  assign dack         = dack_q;
  assign irdata       = irdata_q;
  assign drdata       = drdata_q;
  assign sram_address = sram_address_q;
  assign sram_w_data  = sram_w_data_q;
  assign sram_wen     = sram_wen_q;
  assign sram_ren     = sram_ren_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dyt_sram_arbiter.sv
// tb/tb_dyt_sram_arbiter.sv - self-checking bench for dyt_sram_arbiter
// Emulates the SRAM wrapper and predicts grants, latencies and read data at transaction level.
module tb_dyt_sram_arbiter;
  localparam int RL = 2;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq;
  logic [31:0] iaddr;
  logic        iack;
  logic [31:0] irdata;
  logic        dren;
  logic [3:0]  dwen;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic        dack;
  logic [31:0] drdata;
  logic [31:0] sram_address;
  logic [31:0] sram_w_data;
  logic [3:0]  sram_wen;
  logic        sram_ren;
  logic [31:0] sram_r_data;
  logic        busy;

  dyt_sram_arbiter #(
    .READ_LATENCY(RL), .DATA_WIDTH(32), .ADDR_WIDTH(32), .BYTE_LANES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .iaddr(iaddr), .iack(iack), .irdata(irdata),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dwdata(dwdata),
    .dack(dack), .drdata(drdata),
    .sram_address(sram_address), .sram_w_data(sram_w_data),
    .sram_wen(sram_wen), .sram_ren(sram_ren), .sram_r_data(sram_r_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM wrapper stand-in: byte-lane writes, RL-stage read pipeline clocked by sram_ren.
  logic [31:0] mem  [64];
  logic [31:0] pipe [RL];
  logic        mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      for (int i = 0; i < RL; i++) pipe[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_address[7:2]][8*b +: 8] <= sram_w_data[8*b +: 8];
      if (sram_ren) begin
        pipe[0] <= mem[sram_address[7:2]];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
      end
    end
  end
  assign sram_r_data = pipe[RL-1];

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dren;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        exp_dport;
    logic        exp_write;
    logic [31:0] exp_rdata;
  } vec_t;

  logic [31:0] ref_mem [64];
  logic [31:0] mi, md;
  bit          last_m;
  int          tests, fails;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic [3:0] dw, input logic [31:0] da, input logic [31:0] wd,
                              input logic ed, input logic ew, input logic [31:0] er);
    vec_t v;
    v.ireq = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw; v.daddr = da; v.dwdata = wd;
    v.exp_dport = ed; v.exp_write = ew; v.exp_rdata = er;
    return v;
  endfunction

  // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE cycle.
  task automatic run_vec(input vec_t v, input string nm);
    int          k;
    int          ren_cnt;
    bit          got;
    logic [31:0] ea;
    int          lat;
    ea  = v.exp_dport ? v.daddr : v.iaddr;
    lat = v.exp_write ? 2 : RL + 2;
    ireq = v.ireq; iaddr = v.iaddr; dren = v.dren; dwen = v.dwen;
    daddr = v.daddr; dwdata = v.dwdata;
    k = 0; ren_cnt = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(posedge clk); @(negedge clk); k++;
      if (k == 1) begin
        check({nm, " busy"}, 32'(busy), 32'd1);
        check({nm, " addr"}, sram_address, ea);
        check({nm, " wen"}, 32'(sram_wen), v.exp_write ? 32'(v.dwen) : 32'd0);
        if (v.exp_write) check({nm, " wdata"}, sram_w_data, v.dwdata);
      end
      if (sram_ren) ren_cnt++;
      got = iack | dack;
    end
    check({nm, " ack seen"}, 32'(got), 32'd1);
    check({nm, " latency"}, 32'(k), 32'(lat));
    check({nm, " dack"}, 32'(dack), 32'(v.exp_dport));
    check({nm, " iack"}, 32'(iack), 32'(!v.exp_dport));
    check({nm, " ren cycles"}, 32'(ren_cnt), v.exp_write ? 32'd0 : 32'(RL + 1));
    if (v.exp_write) begin
      for (int b = 0; b < 4; b++)
        if (v.dwen[b]) ref_mem[v.daddr[7:2]][8*b +: 8] = v.dwdata[8*b +: 8];
    end else if (v.exp_dport) begin
      md = v.exp_rdata;
    end else begin
      mi = v.exp_rdata;
    end
    last_m = v.exp_dport;
    check({nm, " drdata"}, drdata, md);
    check({nm, " irdata"}, irdata, mi);
    ireq = 1'b0; dren = 1'b0; dwen = '0;
    @(posedge clk); @(negedge clk);
    check({nm, " ack pulse"}, 32'({iack, dack}), 32'd0);
    check({nm, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    vec_t v;
    int   k;
    bit   bad;
    bit   exp_d;
    bit   dq;
    tests = 0; fails = 0; mem_ready = 1'b0;
    rst = 1'b1; ireq = 1'b0; iaddr = '0; dren = 1'b0; dwen = '0; daddr = '0; dwdata = '0;
    mi = '0; md = '0; last_m = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;

    repeat (3) @(negedge clk);
    mem_ready = 1'b1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset acks", 32'({iack, dack}), 32'd0);
    check("reset irdata", irdata, 32'd0);
    check("reset drdata", drdata, 32'd0);
    check("reset sram_address", sram_address, 32'd0);
    check("reset sram_w_data", sram_w_data, 32'd0);
    check("reset sram_en", 32'({sram_wen, sram_ren}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    tbl[0] = mk(0, 32'h0,  0, 4'hF, 32'h10, 32'hDEADBEEF, 1, 1, 32'h0);
    tbl[1] = mk(0, 32'h0,  1, 4'h0, 32'h10, 32'h0,        1, 0, 32'hDEADBEEF);
    tbl[2] = mk(0, 32'h0,  0, 4'h2, 32'h10, 32'h0000AB00, 1, 1, 32'h0);
    tbl[3] = mk(0, 32'h0,  1, 4'h0, 32'h10, 32'h0,        1, 0, 32'hDEADABEF);
    tbl[4] = mk(1, 32'h10, 0, 4'h0, 32'h0,  32'h0,        0, 0, 32'hDEADABEF);
    tbl[5] = mk(0, 32'h0,  1, 4'hF, 32'h20, 32'h12345678, 1, 1, 32'h0);
    tbl[6] = mk(0, 32'h0,  1, 4'h0, 32'h20, 32'h0,        1, 0, 32'h12345678);
    tbl[7] = mk(1, 32'h20, 0, 4'h0, 32'h0,  32'h0,        0, 0, 32'h12345678);
    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset in the second READ cycle drops the transaction with no ack.
    dren = 1'b1; daddr = 32'h10;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("midread busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midread rst busy", 32'(busy), 32'd0);
    check("midread rst ren", 32'(sram_ren), 32'd0);
    check("midread rst addr", sram_address, 32'd0);
    check("midread rst rdata", drdata | irdata, 32'd0);
    dren = 1'b0;
    @(negedge clk);
    rst = 1'b0; md = '0; mi = '0; last_m = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (iack || dack || busy) bad = 1'b1;
    end
    check("midread no ack after reset", 32'(bad), 32'd0);

    // Both ports held continuously for four transactions.
    ireq = 1'b1; iaddr = 32'h20; dren = 1'b1; daddr = 32'h10; dwen = '0;
    for (int t = 0; t < 4; t++) begin
      k = 0;
      do begin
        @(posedge clk); @(negedge clk); k++;
      end while (!(iack || dack) && k < 40);
      exp_d = RR ? (t % 2 == 0) : 1'b1;
      check($sformatf("contend%0d latency", t), 32'(k), (t == 0) ? 32'(RL + 2) : 32'(RL + 3));
      check($sformatf("contend%0d dack", t), 32'(dack), 32'(exp_d));
      check($sformatf("contend%0d iack", t), 32'(iack), 32'(!exp_d));
      if (exp_d) md = ref_mem[4]; else mi = ref_mem[8];
      last_m = exp_d;
      check($sformatf("contend%0d drdata", t), drdata, md);
      check($sformatf("contend%0d irdata", t), irdata, mi);
    end
    ireq = 1'b0; dren = 1'b0;
    @(posedge clk); @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      v.ireq   = 1'($urandom_range(0, 1));
      v.dren   = 1'($urandom_range(0, 1));
      v.dwen   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      if (!v.ireq && !v.dren && v.dwen == 4'h0) v.ireq = 1'b1;
      v.iaddr  = 32'($urandom_range(0, 63)) << 2;
      v.daddr  = 32'($urandom_range(0, 63)) << 2;
      v.dwdata = $urandom;
      dq = v.dren || (v.dwen != 4'h0);
      if (v.ireq && dq) v.exp_dport = RR ? (last_m == 1'b0) : 1'b1;
      else              v.exp_dport = dq;
      v.exp_write = v.exp_dport && (v.dwen != 4'h0);
      v.exp_rdata = v.exp_write ? 32'h0
                  : ref_mem[v.exp_dport ? v.daddr[7:2] : v.iaddr[7:2]];
      run_vec(v, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
